// File: rtl/tcdm_bank_responder.sv
// Single-ported TCDM bank model: byte-masked word storage, a fixed-latency
// response pipeline that returns the initiator tag, and read/write grant counters.
module tcdm_bank_responder #(
  parameter int unsigned NumIn        = 32,
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned BeWidth      = DataWidth / 8,
  parameter int unsigned AddrMemWidth = 8,
  parameter int unsigned Latency      = 2,
  parameter bit          WriteRespOn  = 1'b1,
  localparam int unsigned IniW        = $clog2(NumIn)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    req_i,
  input  logic [IniW-1:0]         ini_add_i,
  output logic                    gnt_o,
  input  logic [AddrMemWidth-1:0] add_i,
  input  logic                    wen_i,
  input  logic [DataWidth-1:0]    wdata_i,
  input  logic [BeWidth-1:0]      be_i,
  input  logic                    stall_i,
  output logic                    vld_o,
  output logic [IniW-1:0]         ini_add_o,
  output logic [DataWidth-1:0]    rdata_o,
  output logic [31:0]             rd_cnt_o,
  output logic [31:0]             wr_cnt_o
);

  localparam int unsigned Depth = 2 ** AddrMemWidth;

  if ((Latency < 1) || (Latency > 8)) begin : g_latency_check
    $fatal(1, "tcdm_bank_responder: Latency must be in 1..8");
  end

  logic [DataWidth-1:0] mem_r [Depth];
  logic                 gnt_s;
  logic [DataWidth-1:0] rd_word_s;
  logic                 st0_vld_s;
  logic [IniW-1:0]      st0_tag_s;
  logic [DataWidth-1:0] st0_data_s;
  logic [Latency-1:0]   vld_r;
  logic [IniW-1:0]      tag_r  [Latency];
  logic [DataWidth-1:0] data_r [Latency];
  logic [31:0]          rd_cnt_r;
  logic [31:0]          wr_cnt_r;

  assign gnt_s = req_i & ~stall_i;
  assign gnt_o = gnt_s;

  // Stage-0 contents; tag and data are zeroed whenever the stage carries no response
  always_comb begin
    rd_word_s  = mem_r[add_i];
    st0_vld_s  = gnt_s & (~wen_i | WriteRespOn);
    st0_tag_s  = '0;
    st0_data_s = '0;
    if (st0_vld_s) begin
      st0_tag_s = ini_add_i;
    end else begin
      st0_tag_s = '0;
    end
    if (st0_vld_s && !wen_i) begin
      st0_data_s = rd_word_s;
    end else begin
      st0_data_s = '0;
    end
  end

  // Storage is deliberately left out of reset; only granted writes touch it
  always_ff @(posedge clk_i) begin
    if (gnt_s && wen_i) begin
      for (int b = 0; b < int'(BeWidth); b++) begin
        if (be_i[b]) begin
          mem_r[add_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
        end
      end
    end
  end

  // Response shift register: advances every cycle, never stalls
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_r <= '0;
      for (int i = 0; i < int'(Latency); i++) begin
        tag_r[i]  <= '0;
        data_r[i] <= '0;
      end
    end else begin
      vld_r[0]  <= st0_vld_s;
      tag_r[0]  <= st0_tag_s;
      data_r[0] <= st0_data_s;
      for (int i = 1; i < int'(Latency); i++) begin
        vld_r[i]  <= vld_r[i-1];
        tag_r[i]  <= tag_r[i-1];
        data_r[i] <= data_r[i-1];
      end
    end
  end

  // Grant counters, free-running modulo 2**32
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_cnt_r <= 32'd0;
      wr_cnt_r <= 32'd0;
    end else if (gnt_s) begin
      if (wen_i) begin
        wr_cnt_r <= wr_cnt_r + 32'd1;
      end else begin
        rd_cnt_r <= rd_cnt_r + 32'd1;
      end
    end
  end

  assign vld_o     = vld_r[Latency-1];
  assign ini_add_o = tag_r[Latency-1];
  assign rdata_o   = data_r[Latency-1];
  assign rd_cnt_o  = rd_cnt_r;
  assign wr_cnt_o  = wr_cnt_r;

endmodule

// File: tb/tb_tcdm_bank_responder.sv
// Drives three responder instances (Latency 2/3/1, the last without write responses)
// from one stimulus stream and compares them against a grant-history reference model.
module tb_tcdm_bank_responder;

  localparam int N_DUT = 3;
  localparam int LAT [N_DUT]  = '{2, 3, 1};
  localparam bit WRSP [N_DUT] = '{1'b1, 1'b1, 1'b0};
  localparam int HMAX = 4096;

  typedef struct {
    bit          v;
    bit          w;
    logic [4:0]  tag;
    logic [31:0] d;
  } rec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic req, wen, stall;
  logic [4:0]  tag_in;
  logic [7:0]  add;
  logic [31:0] wdata;
  logic [3:0]  be;

  logic [N_DUT-1:0]       gnt_s;
  logic [N_DUT-1:0]       vld_s;
  logic [N_DUT-1:0][4:0]  tag_s;
  logic [N_DUT-1:0][31:0] rd_s;
  logic [N_DUT-1:0][31:0] rc_s;
  logic [N_DUT-1:0][31:0] wc_s;

  rec_t        hist [HMAX];
  logic [31:0] mem_m [256];
  logic [31:0] rd_m, wr_m;
  int k = 0;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  tcdm_bank_responder #(.Latency(2), .WriteRespOn(1'b1)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .ini_add_i(tag_in), .gnt_o(gnt_s[0]),
    .add_i(add), .wen_i(wen), .wdata_i(wdata), .be_i(be), .stall_i(stall),
    .vld_o(vld_s[0]), .ini_add_o(tag_s[0]), .rdata_o(rd_s[0]),
    .rd_cnt_o(rc_s[0]), .wr_cnt_o(wc_s[0]));

  tcdm_bank_responder #(.Latency(3), .WriteRespOn(1'b1)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .ini_add_i(tag_in), .gnt_o(gnt_s[1]),
    .add_i(add), .wen_i(wen), .wdata_i(wdata), .be_i(be), .stall_i(stall),
    .vld_o(vld_s[1]), .ini_add_o(tag_s[1]), .rdata_o(rd_s[1]),
    .rd_cnt_o(rc_s[1]), .wr_cnt_o(wc_s[1]));

  tcdm_bank_responder #(.Latency(1), .WriteRespOn(1'b0)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .ini_add_i(tag_in), .gnt_o(gnt_s[2]),
    .add_i(add), .wen_i(wen), .wdata_i(wdata), .be_i(be), .stall_i(stall),
    .vld_o(vld_s[2]), .ini_add_o(tag_s[2]), .rdata_o(rd_s[2]),
    .rd_cnt_o(rc_s[2]), .wr_cnt_o(wc_s[2]));

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h (edge %0d)", name, act, exp, k);
    end
  endtask

  // Expected response at the current cycle = grant recorded Latency-1 edges ago
  task automatic check_outputs();
    for (int i = 0; i < N_DUT; i++) begin
      int          idx;
      bit          ev;
      logic [4:0]  et;
      logic [31:0] ed;
      idx = k - LAT[i] + 1;
      ev  = 1'b0;
      et  = 5'd0;
      ed  = 32'd0;
      if (idx >= 1 && hist[idx].v && (!hist[idx].w || WRSP[i])) begin
        ev = 1'b1;
        et = hist[idx].tag;
        ed = hist[idx].d;
      end
      check_val($sformatf("vld%0d", i), {31'd0, vld_s[i]}, {31'd0, ev});
      check_val($sformatf("tag%0d", i), {27'd0, tag_s[i]}, {27'd0, et});
      check_val($sformatf("rdata%0d", i), rd_s[i], ed);
      check_val($sformatf("rd_cnt%0d", i), rc_s[i], rd_m);
      check_val($sformatf("wr_cnt%0d", i), wc_s[i], wr_m);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic w, input logic [7:0] a,
                      input logic [31:0] wd, input logic [3:0] b, input logic [4:0] t);
    logic g;
    req = r; stall = s; wen = w; add = a; wdata = wd; be = b; tag_in = t;
    g = r & ~s;
    #1;
    for (int i = 0; i < N_DUT; i++) begin
      check_val($sformatf("gnt%0d", i), {31'd0, gnt_s[i]}, {31'd0, g});
    end
    @(posedge clk);
    k++;
    hist[k].v   = g;
    hist[k].w   = w;
    hist[k].tag = t;
    hist[k].d   = (g && !w) ? mem_m[a] : 32'd0;
    if (g && w) begin
      for (int j = 0; j < 4; j++) begin
        if (b[j]) mem_m[a][j*8 +: 8] = wd[j*8 +: 8];
      end
      wr_m = wr_m + 32'd1;
    end else if (g) begin
      rd_m = rd_m + 32'd1;
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'd0, 32'd0, 4'd0, 5'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = 1'b0;
    #1;
    for (int i = 0; i <= k; i++) hist[i].v = 1'b0;
    rd_m = 32'd0;
    wr_m = 32'd0;
    check_outputs();
    @(posedge clk);
    k++;
    hist[k].v = 1'b0;
    @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
  endtask

  initial begin
    logic        r, s, w;
    logic [7:0]  a;
    logic [31:0] wd;
    logic [3:0]  b;
    logic [4:0]  t;
    for (int i = 0; i < HMAX; i++) hist[i] = '{v: 1'b0, w: 1'b0, tag: 5'd0, d: 32'd0};
    rd_m = 32'd0; wr_m = 32'd0;
    rst_n = 1'b0; req = 1'b0; stall = 1'b0; wen = 1'b0;
    add = 8'd0; wdata = 32'd0; be = 4'd0; tag_in = 5'd0;
    repeat (2) @(negedge clk);
    check_outputs();
    rst_n = 1'b1;

    // Give every word a known value so later reads are defined
    for (int i = 0; i < 256; i++) begin
      wd = $urandom;
      t  = 5'($urandom_range(0, 31));
      step(1'b1, 1'b0, 1'b1, 8'(i), wd, 4'hF, t);
    end
    idle(3);

    // Write then read-after-write to the same word
    step(1'b1, 1'b0, 1'b1, 8'h05, 32'hDEADBEEF, 4'hF, 5'd3);
    step(1'b1, 1'b0, 1'b0, 8'h05, 32'd0, 4'h0, 5'd7);
    check_val("raw_wtag", {27'd0, tag_s[0]}, 32'd3);
    check_val("raw_wdata", rd_s[0], 32'd0);
    idle(1);
    check_val("raw_rtag", {27'd0, tag_s[0]}, 32'd7);
    check_val("raw_rdata", rd_s[0], 32'hDEADBEEF);
    idle(3);

    // Byte-masked write over a known word
    step(1'b1, 1'b0, 1'b1, 8'h20, 32'h11223344, 4'hF, 5'd1);
    step(1'b1, 1'b0, 1'b1, 8'h20, 32'h0000AB00, 4'h2, 5'd1);
    step(1'b1, 1'b0, 1'b0, 8'h20, 32'd0, 4'h0, 5'd2);
    idle(1);
    check_val("be_rdata", rd_s[0], 32'h1122AB44);
    idle(3);

    // Eight back-to-back reads
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 8'(i), 32'd0, 4'h0, 5'(i));
    idle(4);

    // Stalled requests must be invisible
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1, 8'h05, 32'hFFFFFFFF, 4'hF, 5'd9);
    step(1'b1, 1'b0, 1'b0, 8'h05, 32'd0, 4'h0, 5'd4);
    idle(3);
    check_val("stall_mem", mem_m[8'h05], 32'hDEADBEEF);

    // Writes then a read; the no-write-response instance sees only the read
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 8'(i + 40), $urandom, 4'hF, 5'(i));
    step(1'b1, 1'b0, 1'b0, 8'd40, 32'd0, 4'h0, 5'd30);
    idle(4);

    // Randomized traffic on a small address window to exercise hazards
    for (int n = 0; n < 800; n++) begin
      r  = 1'($urandom_range(0, 3) != 0);
      s  = 1'($urandom_range(0, 3) == 0);
      w  = 1'($urandom_range(0, 1));
      a  = 8'($urandom_range(0, 15));
      wd = $urandom;
      b  = 4'($urandom_range(0, 15));
      t  = 5'($urandom_range(0, 31));
      step(r, s, w, a, wd, b, t);
      if (n == 400) begin
        do_reset();
      end
    end
    idle(4);

    // Reset with a read response still in flight
    step(1'b1, 1'b0, 1'b0, 8'h05, 32'd0, 4'h0, 5'd12);
    do_reset();
    check_val("rst_rd_cnt", rc_s[1], 32'd0);
    check_val("rst_wr_cnt", wc_s[1], 32'd0);
    idle(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tcdm_bank_responder.md
TCDM_BANK_RESPONDER -- requirements
Module: tcdm_bank_responder

Interface
REQ-001 Parameter NumIn, 32: number of initiators; sets the initiator-tag width IniW = $clog2(NumIn).
REQ-002 Parameter DataWidth, 32: data word width.
REQ-003 Parameter BeWidth, DataWidth/8: byte-strobe width.
REQ-004 Parameter AddrMemWidth, 8: word-address width; storage holds 2**AddrMemWidth words.
REQ-005 Parameter Latency, 2: cycles from grant to response valid; legal values are 1 to 8.
REQ-006 Parameter WriteRespOn, 1'b1: writes return a response when set.
REQ-007 clk_i  input  1  clock; the block uses a single clock domain.
REQ-008 rst_ni  input  1  asynchronous, active-low reset.
REQ-009 req_i  input  1  request from the interconnect.
REQ-010 ini_add_i  input  IniW  initiator tag of the request.
REQ-011 gnt_o  output  1  grant; the request is accepted this cycle.
REQ-012 add_i  input  AddrMemWidth  word address.
REQ-013 wen_i  input  1  1 = write, 0 = read.
REQ-014 wdata_i  input  DataWidth  write data.
REQ-015 be_i  input  BeWidth  byte enables.
REQ-016 stall_i  input  1  bank busy; suppresses grant.
REQ-017 vld_o  output  1  response valid; there is no ready signal, so the consumer always accepts.
REQ-018 ini_add_o  output  IniW  tag returned with the response.
REQ-019 rdata_o  output  DataWidth  read data.
REQ-020 rd_cnt_o  output  32  count of granted reads.
REQ-021 wr_cnt_o  output  32  count of granted writes.

Function
REQ-022 gnt_o SHALL equal req_i & ~stall_i, combinationally; a request made while stalled has no side effects.
REQ-023 On a granted write, each byte b of word add_i SHALL take wdata_i[b] where be_i[b]=1 and keep its old value where be_i[b]=0; the update is visible from the next cycle.
REQ-024 On a granted read, the word at add_i SHALL be sampled at the clock edge of the grant; a write granted in the previous cycle to the same address SHALL be visible to that read.
REQ-025 The block SHALL keep a response pipeline of Latency stages; each stage holds {valid, tag, data}.
REQ-026 Stage 0 SHALL load valid = grant & (~wen_i | WriteRespOn), together with ini_add_i; data is the read word for a read and all zeros for a write.
REQ-027 Stages SHALL shift by one every cycle, with no stall; vld_o, ini_add_o and rdata_o SHALL be driven from the last stage.
REQ-028 A response for a grant at edge N SHALL appear with vld_o=1 during the cycle following edge N+Latency-1; for Latency=1 this is the cycle after the grant.
REQ-029 Grants on consecutive cycles SHALL produce vld_o on consecutive cycles, in grant order, with no bubbles and no reordering.
REQ-030 When vld_o=0, rdata_o and ini_add_o SHALL be all zeros.
REQ-031 With WriteRespOn=0, a granted write SHALL produce no response but SHALL still advance wr_cnt_o.
REQ-032 rd_cnt_o SHALL increment by 1 on each granted read; wr_cnt_o SHALL increment by 1 on each granted write.
REQ-033 Both counters SHALL wrap modulo 2**32 with no saturation.
REQ-034 The block SHALL be elaborated with a fatal error if Latency is 0 or greater than 8.

Reset
REQ-035 While rst_ni=0: all pipeline valid bits, tags and data SHALL be 0; vld_o=0, ini_add_o=0, rdata_o=0, rd_cnt_o=0, wr_cnt_o=0.
REQ-036 Reset asserted mid-operation SHALL discard all in-flight responses; no vld_o pulse SHALL occur for grants made before reset.
REQ-037 Storage contents SHALL NOT be reset; a read of a never-written word returns an undefined value.
REQ-038 gnt_o SHALL follow REQ-022 regardless of reset; stimulus SHALL keep req_i=0 while rst_ni=0.

Verification
REQ-039 Latency=2, write add=0x05, wdata=0xDEADBEEF, be=0xF, tag=3; next cycle read add=0x05, tag=7 -> write response vld_o with tag 3 and rdata 0, then the following cycle vld_o with tag 7 and rdata 0xDEADBEEF.
REQ-040 Partial write be=0x2, wdata=0x0000AB00 over 0x11223344; then read -> rdata 0x1122AB44.
REQ-041 Eight back-to-back reads, tags 0 to 7, Latency=3 -> vld_o high for 8 consecutive cycles, starting 3 cycles after the first grant, tags 0 to 7 in order; rd_cnt_o=8.
REQ-042 req_i=1 with stall_i=1 for 4 cycles -> gnt_o=0, no vld_o, counters unchanged, memory unchanged.
REQ-043 WriteRespOn=0, three writes then one read -> exactly one vld_o pulse (the read); wr_cnt_o=3, rd_cnt_o=1.
REQ-044 Grant a read, then assert rst_ni=0 for 1 cycle before its response is due -> vld_o stays 0, and both counters read 0 after reset.
